// File: rtl/layer0_input_packer.sv
// layer0_input_packer: quantizes a stream of signed samples to FEAT_BITS each,
// packs NUM_FEAT of them into one word and hands the word to the layer-0
// neurons through a registered valid/ready output slot. A new frame can
// collect while the previous word waits in the output slot.
// Optional build macro: LAST_CHECK_EN enables s_last framing checks and the
// sticky err flag; without it s_last is ignored and err is tied low.
module layer0_input_packer #(
    parameter int IN_W      = 16,
    parameter int NUM_FEAT  = 3,
    parameter int FEAT_BITS = 2,
    parameter int SHIFT     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_W-1:0]               s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [NUM_FEAT*FEAT_BITS-1:0] m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          err
);

    localparam int W     = NUM_FEAT * FEAT_BITS;
    localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int QOFF  = 2 ** (FEAT_BITS - 1);
    localparam int QMAX  = 2 ** FEAT_BITS - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEAT - 1);

    // STALL means the final sample of a frame is due but the output slot is full
    typedef enum logic {
        COLLECT,
        STALL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [W-1:0]     collect;
    logic [W-1:0]     merged;
    logic             accept;
    logic             frame_err;
    logic             load;
    logic             m_valid_next;

    logic signed [IN_W-1:0] t;
    logic signed [IN_W:0]   biased;
    logic [FEAT_BITS-1:0]   q;

    // Quantize: arithmetic shift, offset to unsigned, clamp to the feature range
    always_comb begin
        t      = $signed(s_data) >>> SHIFT;
        biased = $signed({t[IN_W-1], t}) + $signed((IN_W+1)'(QOFF));
        if (biased < 0)
            q = '0;
        else if (biased > $signed((IN_W+1)'(QMAX)))
            q = '1;
        else
            q = biased[FEAT_BITS-1:0];
    end

    // Merge the incoming feature into its slot of the collect buffer
    always_comb begin
        merged = collect;
        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
            if (CNT_W'(k) == cnt)
                merged[k*FEAT_BITS +: FEAT_BITS] = q;
        end
    end

    // Next-state and handshake logic; s_ready is combinational from m_ready so
    // the slot can be refilled in the same cycle the old word is taken
    always_comb begin
        s_ready = !(state == STALL && !m_ready);
        accept  = s_valid & s_ready;
`ifdef LAST_CHECK_EN
        frame_err = accept & (s_last != (cnt == LAST));
`else
        frame_err = 1'b0;
`endif
        load = accept & (cnt == LAST) & ~frame_err;

        cnt_next = cnt;
        if (accept) begin
            if (frame_err || cnt == LAST)
                cnt_next = '0;
            else
                cnt_next = cnt + CNT_W'(1);
        end

        m_valid_next = load | (m_valid & ~m_ready);
        // State tracks "last sample due and slot occupied" one cycle ahead
        state_next   = (cnt_next == LAST && m_valid_next) ? STALL : COLLECT;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_next;
    end

    // Sample counter and collect buffer (not cleared between frames)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            collect <= '0;
        end else begin
            cnt <= cnt_next;
            if (accept && !frame_err)
                collect <= merged;
        end
    end

    // Output slot: load on the last sample, clear valid when taken without refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid_next;
            if (load)
                m_data <= merged;
        end
    end

`ifdef LAST_CHECK_EN
    // Sticky framing error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (frame_err)
            err <= 1'b1;
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign err         = 1'b0;
`endif

endmodule
